// File: rtl/fmax_pool_if.sv
// Beat/result handshake bundle for fmax_pool: LANES operands of W bits in,
// one W-bit maximum plus a sticky NaN flag out.
interface fmax_pool_if #(
    parameter int W     = 12,
    parameter int LANES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    logic                 out_nan;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_nan
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_nan
    );
endinterface

// File: rtl/fmax_pool.sv
// Streaming max-pool over FloPoCo floats: registered lane tree, then a WINDOW-beat fold.
// Optional macro FMAX_POOL_NAN_PROPAGATE_EN makes any NaN operand yield the canonical NaN.
module fmax_pool #(
    parameter int WE     = 5,
    parameter int WF     = 4,
    parameter int LANES  = 4,
    parameter int WINDOW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    fmax_pool_if.slave  bus
);
    localparam int W   = WE + WF + 3;
    localparam int LOG = $clog2(LANES);
    localparam int CW  = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    // Coarse order class: -inf < negative normal < zero < positive normal < +inf.
    function automatic logic signed [2:0] f_class(input logic [W-1:0] x);
        logic signed [2:0] c;
        case (x[W-1:W-2])
            2'b00:   c = 3'sd0;
            2'b01:   c = x[W-3] ? -3'sd1 : 3'sd1;
            2'b10:   c = x[W-3] ? -3'sd2 : 3'sd2;
            default: c = 3'sd0;
        endcase
        return c;
    endfunction

    function automatic logic f_right_gt(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2:0] ca;
        logic signed [2:0] cb;
        logic              gt;
        ca = f_class(a);
        cb = f_class(b);
        if (ca != cb) begin
            gt = (cb > ca);
        end else if (ca == 3'sd1) begin
            gt = (b[W-4:0] > a[W-4:0]);
        end else if (ca == -3'sd1) begin
            gt = (b[W-4:0] < a[W-4:0]);
        end else begin
            gt = 1'b0;
        end
        return gt;
    endfunction

    // Ties keep the left operand, so +0/-0 resolves to whichever came first.
    function automatic logic [W-1:0] f_max(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        if ((a[W-1:W-2] == 2'b11) || (b[W-1:W-2] == 2'b11)) begin
`ifdef FMAX_POOL_NAN_PROPAGATE_EN
            r = {2'b11, {(W-2){1'b0}}};
`else
            r = a;
`endif
        end else if (f_right_gt(a, b)) begin
            r = b;
        end else begin
            r = a;
        end
        return r;
    endfunction

    logic             w_adv;
    logic [LANES-1:0] w_in_nan;
    logic [W-1:0]     w_beat_data;
    logic             w_beat_nan;
    logic             w_beat_valid;

    logic [W-1:0]     r_acc;
    logic             r_acc_nan;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic             r_out_nan;

    logic [W-1:0]     w_fold_data;
    logic             w_fold_nan;
    logic             w_wrap;

    assign w_adv         = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_nan   = r_out_nan;

    // Per-lane NaN flags feeding the sticky window flag.
    always_comb begin
        w_in_nan = '0;
        for (int j = 0; j < LANES; j++) begin
            w_in_nan[j] = (bus.in_data[j*W+W-2 +: 2] == 2'b11);
        end
    end

    generate
        for (genvar s = 0; s < LOG; s++) begin : g_stage
            localparam int NIN  = LANES >> s;
            localparam int NOUT = NIN / 2;

            logic [NIN*W-1:0]  w_prev_data;
            logic [NIN-1:0]    w_prev_nan;
            logic              w_prev_valid;
            logic [NOUT*W-1:0] w_next_data;
            logic [NOUT-1:0]   w_next_nan;
            logic [NOUT*W-1:0] r_data;
            logic [NOUT-1:0]   r_nan;
            logic              r_valid;

            if (s == 0) begin : g_src_in
                assign w_prev_data  = bus.in_data;
                assign w_prev_nan   = w_in_nan;
                assign w_prev_valid = bus.in_valid;
            end else begin : g_src_stage
                assign w_prev_data  = g_stage[s-1].r_data;
                assign w_prev_nan   = g_stage[s-1].r_nan;
                assign w_prev_valid = g_stage[s-1].r_valid;
            end

            // Pairwise reduction; the lower lane is always the left operand.
            always_comb begin
                w_next_data = '0;
                w_next_nan  = '0;
                for (int j = 0; j < NOUT; j++) begin
                    w_next_data[j*W +: W] = f_max(w_prev_data[2*j*W +: W],
                                                  w_prev_data[(2*j+1)*W +: W]);
                    w_next_nan[j] = w_prev_nan[2*j] | w_prev_nan[2*j+1];
                end
            end

            // Tree stage register, frozen with the rest of the pipe on stall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_nan   <= '0;
                    r_valid <= 1'b0;
                end else if (w_adv) begin
                    r_data  <= w_next_data;
                    r_nan   <= w_next_nan;
                    r_valid <= w_prev_valid;
                end
            end
        end

        if (LOG == 0) begin : g_beat_in
            assign w_beat_data  = bus.in_data[W-1:0];
            assign w_beat_nan   = w_in_nan[0];
            assign w_beat_valid = bus.in_valid;
        end else begin : g_beat_tree
            assign w_beat_data  = g_stage[LOG-1].r_data;
            assign w_beat_nan   = g_stage[LOG-1].r_nan[0];
            assign w_beat_valid = g_stage[LOG-1].r_valid;
        end
    endgenerate

    // First beat of a window loads directly; later beats fold against the running max.
    always_comb begin
        w_wrap = (r_cnt == CW'(WINDOW - 1));
        if (r_cnt != '0) begin
            w_fold_data = f_max(r_acc, w_beat_data);
            w_fold_nan  = r_acc_nan | w_beat_nan;
        end else begin
            w_fold_data = w_beat_data;
            w_fold_nan  = w_beat_nan;
        end
    end

    // Window accumulator and output register; a completing window may replace a result being taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_acc_nan   <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_nan   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= 1'b0;
            if (w_beat_valid) begin
                if (w_wrap) begin
                    r_cnt       <= '0;
                    r_out_data  <= w_fold_data;
                    r_out_nan   <= w_fold_nan;
                    r_out_valid <= 1'b1;
                end else begin
                    r_cnt     <= r_cnt + CW'(1);
                    r_acc     <= w_fold_data;
                    r_acc_nan <= w_fold_nan;
                end
            end
        end
    end
endmodule
